// File: rtl/issue_ctrl_if.sv
// Frontend-to-issue handshake: the two FIFO head instructions with their
// per-slot decode flags, and the read count returned to the FIFO.
package issue_ctrl_pkg;
    typedef struct packed {
        logic [15:0] op;
        logic [4:0]  w_reg;
        logic [4:0]  r_reg0;
        logic [4:0]  r_reg1;
    } inst_t;
endpackage

interface issue_ctrl_if;
    import issue_ctrl_pkg::*;

    inst_t [1:0] inst;
    logic  [1:0] inst_valid;
    logic  [1:0] long_lat;
    logic  [1:0] is_mem;
    logic  [1:0] solo;
    logic  [1:0] issue_num;

    modport master (
        output inst, inst_valid, long_lat, is_mem, solo,
        input  issue_num
    );

    modport slave (
        input  inst, inst_valid, long_lat, is_mem, solo,
        output issue_num
    );
endinterface

// File: rtl/issue_ctrl.sv
// Dual-issue stage with a per-register pending-writer scoreboard for RAW stalls.
// Optional statistics counters are built only when ISSUE_CTRL_STAT_EN is defined.
module issue_ctrl_sva (
    input logic clk,
    input logic rst,
    input logic underflow_i
);
    // A release must never outnumber the counted writers of a register.
    property p_no_underflow;
        @(posedge clk) disable iff (rst) !underflow_i;
    endproperty
    a_no_underflow: assert property (p_no_underflow);
endmodule

module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int REG_NUM  = 32,
    parameter int SB_CNT_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    issue_ctrl_if.slave          fe,
    input  logic                 backend_stall_i,
    input  logic                 flush_i,
    input  logic [1:0]           wb_release_valid_i,
    input  logic [1:0][4:0]      wb_release_reg_i,
    output inst_t [1:0]          inst_o,
    output logic  [1:0]          inst_valid_o,
    output logic  [31:0]         hazard_stall_cnt_o,
    output logic  [31:0]         dual_issue_cnt_o
);
    localparam int CW = SB_CNT_W + 2;
    localparam logic [SB_CNT_W-1:0] SB_MAX = '1;

    logic [SB_CNT_W-1:0] sb_q [REG_NUM];
    logic [SB_CNT_W-1:0] sb_d [REG_NUM];
    inst_t [1:0]         inst_q, inst_d;
    logic  [1:0]         inst_valid_q, inst_valid_d;

    logic [1:0]          hz_s;
    logic                i0_s, i1_s;
    logic                raw_s, waw_s;
    logic [REG_NUM-1:0]  underflow_s;

    // Per-slot hazard: pending writer on a source, or saturated counter on a long-latency destination.
    always_comb begin
        hz_s = 2'b00;
        for (int s = 0; s < 2; s++) begin
            hz_s[s] = ((fe.inst[s].r_reg0 != 5'd0) && (sb_q[fe.inst[s].r_reg0] != '0))
                   || ((fe.inst[s].r_reg1 != 5'd0) && (sb_q[fe.inst[s].r_reg1] != '0))
                   || (fe.long_lat[s] && (fe.inst[s].w_reg != 5'd0)
                       && (sb_q[fe.inst[s].w_reg] == SB_MAX));
        end
    end

    // Issue decision; slot 1 only ever issues alongside slot 0.
    always_comb begin
        raw_s = (fe.inst[0].w_reg != 5'd0)
             && ((fe.inst[0].w_reg == fe.inst[1].r_reg0) || (fe.inst[0].w_reg == fe.inst[1].r_reg1));
        waw_s = fe.long_lat[0] && fe.long_lat[1] && (fe.inst[0].w_reg != 5'd0)
             && (fe.inst[0].w_reg == fe.inst[1].w_reg);
        i0_s  = fe.inst_valid[0] && !hz_s[0] && !backend_stall_i && !flush_i && !rst;
        i1_s  = i0_s && fe.inst_valid[1] && !hz_s[1] && !fe.solo[0] && !fe.solo[1]
             && !(fe.is_mem[0] && fe.is_mem[1]) && !raw_s && !waw_s;
    end

    assign fe.issue_num = {1'b0, i0_s} + {1'b0, i1_s};

    // Execute-stage input register next state: flush beats stall, stall holds.
    always_comb begin
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        if (flush_i) begin
            inst_valid_d = 2'b00;
        end else if (backend_stall_i) begin
            inst_valid_d = inst_valid_q;
        end else begin
            inst_d       = fe.inst;
            inst_valid_d = {i1_s, i0_s};
        end
    end

    // Scoreboard next state: issued long-latency writers minus releases, clamped at zero.
    always_comb begin
        logic [CW-1:0] inc, dec, sum;
        sb_d[0]     = '0;
        underflow_s = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            inc = CW'(i0_s && fe.long_lat[0] && (fe.inst[0].w_reg == 5'(r)))
                + CW'(i1_s && fe.long_lat[1] && (fe.inst[1].w_reg == 5'(r)));
            dec = CW'(wb_release_valid_i[0] && (wb_release_reg_i[0] == 5'(r)))
                + CW'(wb_release_valid_i[1] && (wb_release_reg_i[1] == 5'(r)));
            sum = CW'(sb_q[r]) + inc;
            if (dec > sum) begin
                sb_d[r]        = '0;
                underflow_s[r] = 1'b1;
            end else begin
                sb_d[r] = SB_CNT_W'(sum - dec);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q       <= '0;
            inst_valid_q <= 2'b00;
            for (int r = 0; r < REG_NUM; r++) sb_q[r] <= '0;
        end else begin
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            for (int r = 0; r < REG_NUM; r++) sb_q[r] <= sb_d[r];
        end
    end

    assign inst_o       = inst_q;
    assign inst_valid_o = inst_valid_q;

`ifdef ISSUE_CTRL_STAT_EN
    logic [31:0] hazard_cnt_q, hazard_cnt_d;
    logic [31:0] dual_cnt_q, dual_cnt_d;

    // Statistic counters next state; both wrap naturally.
    always_comb begin
        if (fe.inst_valid[0] && !backend_stall_i && !flush_i && !i0_s) begin
            hazard_cnt_d = hazard_cnt_q + 32'd1;
        end else begin
            hazard_cnt_d = hazard_cnt_q;
        end
        if (i1_s) begin
            dual_cnt_d = dual_cnt_q + 32'd1;
        end else begin
            dual_cnt_d = dual_cnt_q;
        end
    end

    // Statistic counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hazard_cnt_q <= 32'd0;
            dual_cnt_q   <= 32'd0;
        end else begin
            hazard_cnt_q <= hazard_cnt_d;
            dual_cnt_q   <= dual_cnt_d;
        end
    end

    assign hazard_stall_cnt_o = hazard_cnt_q;
    assign dual_issue_cnt_o   = dual_cnt_q;
`else
    assign hazard_stall_cnt_o = 32'd0;
    assign dual_issue_cnt_o   = 32'd0;
`endif

    issue_ctrl_sva u_sva (
        .clk         (clk),
        .rst         (rst),
        .underflow_i (|underflow_s)
    );
endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Issue stage directly downstream of the frontend instruction FIFO.
- Each cycle it inspects the two FIFO head instructions and decides how many to issue (0/1/2). It returns that count to the FIFO as its read count and registers the issued pair into the execute-stage input registers.
- Tracks in-flight long-latency writers (loads, mul/div) in a per-register scoreboard and stalls on RAW hazards against them.

Parameters:
- REG_NUM, 32, number of architectural GPRs; r0 is never tracked.
- SB_CNT_W, 2, width of each scoreboard pending-writer counter; max value 2^SB_CNT_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- inst_i  in  2x$bits(inst_t)  FIFO head instructions; slot 0 is the older one.
- inst_valid_i  in  2  per-slot FIFO valid; 2'b10 never occurs.
- long_lat_i  in  2  per-slot long-latency writer flag (load/mul/div), decoded by the parent from decode_info.
- is_mem_i  in  2  per-slot memory-access flag.
- solo_i  in  2  per-slot single-issue flag (CSR/priv/barrier).
- issue_num_o  out  2  FIFO read count (0/1/2); combinational.
- backend_stall_i  in  1  execute stage cannot accept.
- flush_i  in  1  pipeline flush from backend redirect.
- wb_release_valid_i  in  2  per-port long-latency writeback release.
- wb_release_reg_i  in  2x5  register released per port.
- inst_o  out  2x$bits(inst_t)  registered issued instructions.
- inst_valid_o  out  2  registered per-slot valid.
- hazard_stall_cnt_o  out  32  stall statistic (optional feature).
- dual_issue_cnt_o  out  32  dual-issue statistic (optional feature).

Behaviour:
- Reset (rst=1 at a clk edge):
  - inst_valid_o=0, inst_o=0.
  - All scoreboard counters=0; statistic counters=0.
  - issue_num_o=0 while rst is high.
- Hazard definition:
  - hz(s) is true if any nonzero r_reg of slot s has sb[r]!=0.
  - hz(s) is also true if slot s has long_lat=1, w_reg!=0, and sb[w_reg] is at max (saturation stall).
- Slot 0 issues (i0) when:
  - inst_valid_i[0], !hz(0), !backend_stall_i, !flush_i, !rst.
- Slot 1 issues (i1) when i0 and all of the following hold:
  - inst_valid_i[1] and !hz(1).
  - !solo_i[0] and !solo_i[1].
  - !(is_mem_i[0] & is_mem_i[1]).
  - No intra-pair RAW: slot0 w_reg is nonzero and equal to a slot1 r_reg → block slot 1.
  - No intra-pair WAW on a long-latency pair: both slots long_lat with the same nonzero w_reg → block slot 1.
- Issue count: issue_num_o = i0 + i1 (i1 implies i0). Slot 1 never issues alone.
- Output register, on the next clk edge:
  - backend_stall_i=1 and no flush: hold inst_o and inst_valid_o unchanged.
  - flush_i=1: inst_valid_o←0 regardless of backend_stall_i.
  - Otherwise: inst_o←inst_i and inst_valid_o←{i1,i0}. Non-issued slots load with valid=0.
- Latency: an instruction issued in cycle N is visible on inst_o in cycle N+1.
- Scoreboard update each cycle, per register r:
  - inc = number of issued slots with long_lat=1 and w_reg==r (r!=0).
  - dec = number of release ports with valid and reg==r.
  - sb[r] ← sb[r] + inc − dec.
  - Simultaneous inc/dec on the same register nets out.
  - Underflow (dec > sb[r]+inc) is a backend protocol violation: clamp to 0, flagged by a simulation-only assertion.
  - Release of r0 is ignored.
- flush_i does not clear the scoreboard. The backend guarantees exactly one release for every counted issue, including killed instructions.
- Releases take effect on the clk edge. A consumer waiting on r can issue in the cycle after the release cycle, not in the same cycle.

Optional Feature:
- Macro: ISSUE_CTRL_STAT_EN.
- Defined:
  - hazard_stall_cnt_o increments on every cycle with inst_valid_i[0]=1, !backend_stall_i, !flush_i and i0=0.
  - dual_issue_cnt_o increments on every cycle with i1=1.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both outputs are constant 0 and no counter flops are synthesized.

Test Plan:
- Reset, then present slot0 "add r4,r2,r3" and slot1 "add r5,r6,r7", both valid, empty scoreboard → issue_num_o=2; next cycle inst_valid_o=2'b11.
- Slot0 "add r4,r2,r3", slot1 "sub r6,r4,r1" → issue_num_o=1; inst_valid_o=2'b01. Next cycle, with the sub now at slot 0 → issue_num_o≥1.
- Issue "ld.w r8" (long_lat). Then present "add r9,r8,r8" at slot 0 → issue_num_o=0 each cycle until wb_release_valid_i[0]=1 with reg=8. The add issues in the cycle after the release, and sb[8] returns to 0.
- Slot0 load and slot1 store (is_mem 11) → issue_num_o=1. Slot0 solo_i=1 → issue_num_o=1.
- backend_stall_i=1 for 3 cycles with valid input → issue_num_o=0 and inst_o/inst_valid_o held. Assert flush_i during the stall → inst_valid_o=0 next cycle and scoreboard unchanged.
- With ISSUE_CTRL_STAT_EN: 5 dual-issue cycles followed by 3 hazard cycles → dual_issue_cnt_o=5 and hazard_stall_cnt_o=3. Without the macro, both outputs read 0.
